// File: rtl/in_fm_tile_loader_if.sv
// Bundle of the tile loader's control, RAM-read and lane-FIFO signals.
// master = loader side, slave = RAM/FIFO/controller side.
interface in_fm_tile_loader_if #(
   parameter int CW  = 32,
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int NCH = 2
);
   logic              start;
   logic              done;
   logic              busy;
   logic [CW-1:0]     tile_base_m;
   logic [CW-1:0]     tile_base_row;
   logic [CW-1:0]     tile_base_col;
   logic              ram_rd_en;
   logic [AW-1:0]     ram_addr;
   logic [DW-1:0]     data_from_ram;
   logic [NCH-1:0]    fifo_almost_full;
   logic [NCH-1:0]    fifo_push;
   logic [NCH*DW-1:0] data_to_fifo;

   modport master (
      input  start, tile_base_m, tile_base_row, tile_base_col,
      input  data_from_ram, fifo_almost_full,
      output done, busy, ram_rd_en, ram_addr, fifo_push, data_to_fifo
   );

   modport slave (
      output start, tile_base_m, tile_base_row, tile_base_col,
      output data_from_ram, fifo_almost_full,
      input  done, busy, ram_rd_en, ram_addr, fifo_push, data_to_fifo
   );
endinterface

// File: rtl/in_fm_tile_loader.sv
// Multi-lane in_fm tile loader: walks one Tm x Tr x Tc tile and streams it into NCH lane FIFOs.
// Optional IN_FM_ZERO_PAD_EN: out-of-range elements push zeros instead of being skipped.
module in_fm_tile_loader #(
   parameter int CW     = 32,
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int M      = 32,
   parameter int R      = 64,
   parameter int C      = 32,
   parameter int Tm     = 8,
   parameter int Tr     = 16,
   parameter int Tc     = 8,
   parameter int NCH    = 2,
   parameter int RD_LAT = 2
) (
   input logic                 clk,
   input logic                 rst,
   in_fm_tile_loader_if.master bus
);
   localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

   state_t        state;
   logic [CW-1:0] bm, br, bc;
   logic [CW-1:0] tm, tr, tc;
   logic          done_r, busy_r;

   logic [CW:0]   abs_m, abs_r, abs_c;
   logic [AW-1:0] addr;
   logic [LW-1:0] lane;
   logic          oor, advance, last_elem, pipe_busy;
   logic          enq_valid, enq_pad;

   // read pipeline: {valid, lane, pad} per stage, tail at index RD_LAT-1
   logic          pv [RD_LAT];
   logic [LW-1:0] pl [RD_LAT];
   logic          pp [RD_LAT];

   assign abs_m = {1'b0, bm} + {1'b0, tm};
   assign abs_r = {1'b0, br} + {1'b0, tr};
   assign abs_c = {1'b0, bc} + {1'b0, tc};

   assign oor = (abs_m >= (CW+1)'(M)) || (abs_r >= (CW+1)'(R)) || (abs_c >= (CW+1)'(C));

   assign addr = AW'(abs_m) * AW'(R * C) + AW'(abs_r) * AW'(C) + AW'(abs_c);

   assign lane      = LW'(tm % CW'(NCH));
   assign advance   = (state == ISSUE) && !bus.fifo_almost_full[lane];
   assign last_elem = (tm == CW'(Tm - 1)) && (tr == CW'(Tr - 1)) && (tc == CW'(Tc - 1));

`ifdef IN_FM_ZERO_PAD_EN
   assign enq_valid = advance;
   assign enq_pad   = oor;
`else
   assign enq_valid = advance && !oor;
   assign enq_pad   = 1'b0;
`endif

   // issue gating must react to almost_full in the same cycle, so the read request is combinational
   assign bus.ram_rd_en = advance && !oor;
   assign bus.ram_addr  = (state == ISSUE) ? addr : '0;
   assign bus.done      = done_r;
   assign bus.busy      = busy_r;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         bm     <= '0;
         br     <= '0;
         bc     <= '0;
         tm     <= '0;
         tr     <= '0;
         tc     <= '0;
         done_r <= 1'b0;
         busy_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state  <= ISSUE;
                  bm     <= bus.tile_base_m;
                  br     <= bus.tile_base_row;
                  bc     <= bus.tile_base_col;
                  tm     <= '0;
                  tr     <= '0;
                  tc     <= '0;
                  busy_r <= 1'b1;
               end
            end
            ISSUE: begin
               if (advance) begin
                  if (last_elem) state <= DRAIN;
                  if (tc == CW'(Tc - 1)) begin
                     tc <= '0;
                     if (tr == CW'(Tr - 1)) begin
                        tr <= '0;
                        tm <= tm + 1'b1;
                     end else begin
                        tr <= tr + 1'b1;
                     end
                  end else begin
                     tc <= tc + 1'b1;
                  end
               end
            end
            DRAIN: begin
               // the tail word pushes this cycle, so only the upstream stages must be empty
               if (!pipe_busy) begin
                  state  <= FIN;
                  done_r <= 1'b1;
               end
            end
            FIN: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            pv[i] <= 1'b0;
            pl[i] <= '0;
            pp[i] <= 1'b0;
         end
      end else begin
         pv[0] <= enq_valid;
         pl[0] <= lane;
         pp[0] <= enq_pad;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            pv[i] <= pv[i-1];
            pl[i] <= pl[i-1];
            pp[i] <= pp[i-1];
         end
      end
   end

   always_comb begin
      pipe_busy = 1'b0;
      for (int unsigned i = 0; i < RD_LAT - 1; i++) pipe_busy = pipe_busy | pv[i];
   end

   always_comb begin
      bus.fifo_push    = '0;
      bus.data_to_fifo = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (pv[RD_LAT-1] && (pl[RD_LAT-1] == LW'(k))) begin
            bus.fifo_push[k]              = 1'b1;
            bus.data_to_fifo[k*DW +: DW]  = pp[RD_LAT-1] ? '0 : bus.data_from_ram;
         end
      end
   end
endmodule

// File: tb/tb_in_fm_tile_loader.sv
// Scoreboard bench for in_fm_tile_loader on a 4x4x4 map with 2x2x2 tiles and two lanes.
module tb_in_fm_tile_loader;
   localparam int CW = 32, AW = 32, DW = 32;
   localparam int M = 4, R = 4, C = 4, TM = 2, TR = 2, TC = 2, NCH = 2;
   parameter int RD_LAT = 2;
   localparam int N = TM * TR * TC;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   in_fm_tile_loader_if #(.CW(CW), .AW(AW), .DW(DW), .NCH(NCH)) bus ();

   in_fm_tile_loader #(
      .CW(CW), .AW(AW), .DW(DW), .M(M), .R(R), .C(C),
      .Tm(TM), .Tr(TR), .Tc(TC), .NCH(NCH), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: word[a] = a, returned RD_LAT cycles after the request
   logic [AW-1:0] rpipe [RD_LAT];
   always @(posedge clk) begin
      rpipe[0] <= bus.ram_rd_en ? bus.ram_addr : 32'hDEAD_BEEF;
      for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign bus.data_from_ram = rpipe[RD_LAT-1];

   logic [DW-1:0] exp_q [NCH][$];
   logic [DW-1:0] obs_q [NCH][$];
   int obs_cyc[$];
   int done_q[$];
   int busy_q[$];
   int multi_push = 0;

   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < NCH; k++) begin
            if (bus.fifo_push[k]) begin
               obs_q[k].push_back(bus.data_to_fifo[k*DW +: DW]);
               obs_cyc.push_back(cyc);
            end
         end
         if ($countones(bus.fifo_push) > 1) multi_push++;
         if (bus.done) done_q.push_back(cyc);
         if (bus.busy) busy_q.push_back(cyc);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      for (int k = 0; k < NCH; k++) begin
         obs_q[k].delete();
         exp_q[k].delete();
      end
      obs_cyc.delete();
      done_q.delete();
      busy_q.delete();
      multi_push = 0;
   endtask

   task automatic push_nominal();
      int v [4];
      v = '{0, 1, 4, 5};
      for (int i = 0; i < 4; i++) begin
         exp_q[0].push_back(DW'(v[i]));
         exp_q[1].push_back(DW'(v[i] + 16));
      end
   endtask

   // bases are scrambled after the start cycle so only latched values can matter
   task automatic do_start(input int m0, input int r0, input int c0, output int t);
      bus.tile_base_m   = CW'(m0);
      bus.tile_base_row = CW'(r0);
      bus.tile_base_col = CW'(c0);
      bus.start = 1'b1;
      t = cyc;
      tick(1);
      bus.start = 1'b0;
      bus.tile_base_m   = CW'(1);
      bus.tile_base_row = CW'(1);
      bus.tile_base_col = CW'(1);
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      bus.fifo_almost_full = '0;
      bus.tile_base_m = '0;
      bus.tile_base_row = '0;
      bus.tile_base_col = '0;
      rst = 1'b0;
      tick(3);
      tests++;
      if ({bus.done, bus.busy, bus.ram_rd_en, bus.ram_addr, bus.fifo_push, bus.data_to_fifo} !== '0) begin
         fails++;
         $display("FAIL reset_outputs got rd_en=%b addr=%0h push=%b busy=%b done=%b want all 0",
                  bus.ram_rd_en, bus.ram_addr, bus.fifo_push, bus.busy, bus.done);
      end
      rst = 1'b1;
      tick(2);
      tests++;
      if ({bus.busy, bus.done, bus.ram_rd_en} !== 3'b000) begin
         fails++;
         $display("FAIL idle_after_reset got busy=%b done=%b rd_en=%b want 000", bus.busy, bus.done, bus.ram_rd_en);
      end
   endtask

   task automatic test_nominal();
      int t;
      clear_obs();
      push_nominal();
      do_start(0, 0, 0, t);
      tick(N + RD_LAT + 6);
      for (int k = 0; k < NCH; k++) begin
         tests++;
         if (obs_q[k].size() != exp_q[k].size()) begin
            fails++;
            $display("FAIL nominal_count lane%0d got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
         end else begin
            for (int i = 0; i < exp_q[k].size(); i++) begin
               tests++;
               if (obs_q[k][i] !== exp_q[k][i]) begin
                  fails++;
                  $display("FAIL nominal_data lane%0d[%0d] got %0d want %0d", k, i, obs_q[k][i], exp_q[k][i]);
               end
            end
         end
      end
      tests++;
      if (obs_cyc.size() == 0 || obs_cyc[0] != t + 1 + RD_LAT) begin
         fails++;
         $display("FAIL nominal_first_push got %0d want %0d", obs_cyc.size() ? obs_cyc[0] - t : -1, 1 + RD_LAT);
      end
      tests++;
      if (done_q.size() != 1 || done_q[0] != t + N + RD_LAT + 1) begin
         fails++;
         $display("FAIL nominal_done got n=%0d at %0d want n=1 at %0d", done_q.size(),
                  done_q.size() ? done_q[0] - t : -1, N + RD_LAT + 1);
      end
      tests++;
      if (busy_q.size() != N + RD_LAT + 1 || busy_q[0] != t + 1 || busy_q[busy_q.size()-1] != t + N + RD_LAT + 1) begin
         fails++;
         $display("FAIL nominal_busy got %0d cycles from %0d want %0d from 1", busy_q.size(),
                  busy_q.size() ? busy_q[0] - t : -1, N + RD_LAT + 1);
      end
      tests++;
      if (multi_push != 0) begin
         fails++;
         $display("FAIL one_push_per_cycle got %0d multi-push cycles want 0", multi_push);
      end
   endtask

   task automatic test_back_pressure();
      int t;
      clear_obs();
      push_nominal();
      do_start(0, 0, 0, t);
      tick(4);
      bus.fifo_almost_full = 2'b10;
      tick(5);
      bus.fifo_almost_full = 2'b00;
      tick(N + RD_LAT + 10);
      for (int k = 0; k < NCH; k++) begin
         tests++;
         if (obs_q[k].size() != exp_q[k].size()) begin
            fails++;
            $display("FAIL bp_count lane%0d got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
         end else begin
            for (int i = 0; i < exp_q[k].size(); i++) begin
               tests++;
               if (obs_q[k][i] !== exp_q[k][i]) begin
                  fails++;
                  $display("FAIL bp_data lane%0d[%0d] got %0d want %0d", k, i, obs_q[k][i], exp_q[k][i]);
               end
            end
         end
      end
      tests++;
      if (done_q.size() != 1 || done_q[0] != t + N + RD_LAT + 1 + 5) begin
         fails++;
         $display("FAIL bp_done got n=%0d at %0d want n=1 at %0d", done_q.size(),
                  done_q.size() ? done_q[0] - t : -1, N + RD_LAT + 6);
      end
   endtask

   task automatic test_edge_tile();
      int t;
      clear_obs();
      exp_q[0].push_back(DW'(47));
      exp_q[1].push_back(DW'(63));
`ifdef IN_FM_ZERO_PAD_EN
      for (int i = 0; i < 3; i++) begin
         exp_q[0].push_back('0);
         exp_q[1].push_back('0);
      end
`endif
      do_start(2, 3, 3, t);
      tick(N + RD_LAT + 6);
      for (int k = 0; k < NCH; k++) begin
         tests++;
         if (obs_q[k].size() != exp_q[k].size()) begin
            fails++;
            $display("FAIL edge_count lane%0d got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
         end else begin
            for (int i = 0; i < exp_q[k].size(); i++) begin
               tests++;
               if (obs_q[k][i] !== exp_q[k][i]) begin
                  fails++;
                  $display("FAIL edge_data lane%0d[%0d] got %0d want %0d", k, i, obs_q[k][i], exp_q[k][i]);
               end
            end
         end
      end
      tests++;
      if (done_q.size() != 1) begin
         fails++;
         $display("FAIL edge_done_count got %0d want 1", done_q.size());
      end
`ifdef IN_FM_ZERO_PAD_EN
      tests++;
      if (done_q.size() != 1 || done_q[0] != t + N + RD_LAT + 1) begin
         fails++;
         $display("FAIL edge_done_time got %0d want %0d", done_q.size() ? done_q[0] - t : -1, N + RD_LAT + 1);
      end
`endif
   endtask

   task automatic test_start_while_busy();
      int t;
      clear_obs();
      push_nominal();
      do_start(0, 0, 0, t);
      tick(2);
      bus.tile_base_m   = CW'(2);
      bus.tile_base_row = CW'(2);
      bus.tile_base_col = CW'(2);
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      tick(N + RD_LAT + 6);
      for (int k = 0; k < NCH; k++) begin
         tests++;
         if (obs_q[k].size() != exp_q[k].size()) begin
            fails++;
            $display("FAIL busy_start_count lane%0d got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
         end else begin
            for (int i = 0; i < exp_q[k].size(); i++) begin
               tests++;
               if (obs_q[k][i] !== exp_q[k][i]) begin
                  fails++;
                  $display("FAIL busy_start_data lane%0d[%0d] got %0d want %0d", k, i, obs_q[k][i], exp_q[k][i]);
               end
            end
         end
      end
      tests++;
      if (done_q.size() != 1 || done_q[0] != t + N + RD_LAT + 1) begin
         fails++;
         $display("FAIL busy_start_done got n=%0d want n=1 at %0d", done_q.size(), N + RD_LAT + 1);
      end
   endtask

   task automatic test_reset_mid();
      int t;
      clear_obs();
      do_start(0, 0, 0, t);
      tick(3);
      rst = 1'b0;
      #1;
      tests++;
      if ({bus.done, bus.busy, bus.ram_rd_en, bus.ram_addr, bus.fifo_push, bus.data_to_fifo} !== '0) begin
         fails++;
         $display("FAIL midreset_outputs got rd_en=%b addr=%0h push=%b busy=%b want all 0",
                  bus.ram_rd_en, bus.ram_addr, bus.fifo_push, bus.busy);
      end
      tick(2);
      rst = 1'b1;
      tick(2);
      clear_obs();
      push_nominal();
      do_start(0, 0, 0, t);
      tick(N + RD_LAT + 6);
      for (int k = 0; k < NCH; k++) begin
         tests++;
         if (obs_q[k].size() != exp_q[k].size()) begin
            fails++;
            $display("FAIL midreset_count lane%0d got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
         end else begin
            for (int i = 0; i < exp_q[k].size(); i++) begin
               tests++;
               if (obs_q[k][i] !== exp_q[k][i]) begin
                  fails++;
                  $display("FAIL midreset_data lane%0d[%0d] got %0d want %0d", k, i, obs_q[k][i], exp_q[k][i]);
               end
            end
         end
      end
      tests++;
      if (done_q.size() != 1 || done_q[0] != t + N + RD_LAT + 1) begin
         fails++;
         $display("FAIL midreset_done got n=%0d want n=1 at %0d", done_q.size(), N + RD_LAT + 1);
      end
   endtask

   task automatic test_back_to_back();
      int t, t2;
      clear_obs();
      push_nominal();
      push_nominal();
      do_start(0, 0, 0, t);
      tick(N + RD_LAT);
      bus.tile_base_m   = '0;
      bus.tile_base_row = '0;
      bus.tile_base_col = '0;
      bus.start = 1'b1;
      tick(1);
      t2 = cyc;
      tick(1);
      bus.start = 1'b0;
      tick(N + RD_LAT + 6);
      for (int k = 0; k < NCH; k++) begin
         tests++;
         if (obs_q[k].size() != exp_q[k].size()) begin
            fails++;
            $display("FAIL b2b_count lane%0d got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
         end else begin
            for (int i = 0; i < exp_q[k].size(); i++) begin
               tests++;
               if (obs_q[k][i] !== exp_q[k][i]) begin
                  fails++;
                  $display("FAIL b2b_data lane%0d[%0d] got %0d want %0d", k, i, obs_q[k][i], exp_q[k][i]);
               end
            end
         end
      end
      tests++;
      if (done_q.size() != 2 || done_q[1] != t2 + N + RD_LAT + 1) begin
         fails++;
         $display("FAIL b2b_done got n=%0d last at %0d want n=2 at %0d", done_q.size(),
                  done_q.size() ? done_q[done_q.size()-1] - t2 : -1, N + RD_LAT + 1);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_back_pressure();
      test_edge_tile();
      test_start_while_busy();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
